// File: rtl/digital_tube_ctrl_pkg.sv
// Shared definitions for the 8-digit multiplexed 7-segment display peripheral.
// Bus word select, CTRL bit layout, reset and blanking values.
package digital_tube_ctrl_pkg;

    typedef enum logic {
        ADDR_DATA = 1'b0,
        ADDR_CTRL = 1'b1
    } addr_sel_e;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_DP_LSB = 8;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
    // Only the enable bit and the decimal-point byte are implemented.
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FF01;

    localparam logic [7:0] BLANK_SEG = 8'hFF;
    localparam logic [3:0] BLANK_SEL = 4'hF;

endpackage

// File: rtl/digital_tube_ctrl_hex_to_seg7.sv
// Combinational hex digit to 7-segment glyph decoder, active-high {g,f,e,d,c,b,a}.
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        unique case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = '0;
        endcase
    end

endmodule

// File: rtl/digital_tube_ctrl.sv
// Bus-writable driver for two 4-digit active-low multiplexed 7-segment displays.
// Holds DATA/CTRL, the scan counter and the registered digit/segment outputs.
module digital_tube_ctrl
    import digital_tube_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] WD,
    output logic [31:0] O,
    output logic [3:0]  sel0,
    output logic [3:0]  sel1,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [31:0]   data, data_nx;
    logic [31:0]   ctrl, ctrl_nx;
    logic          scan_wrap;
    addr_sel_e     asel;

    logic [3:0] nib0, nib1;
    logic [6:0] glyph0, glyph1;
    logic [7:0] dpmask;
    logic [3:0] sel_nx;
    logic [7:0] seg0_nx, seg1_nx;

    logic unused_addr;
    assign unused_addr = ^{Addr[31:3], Addr[1:0]};

    assign asel      = addr_sel_e'(Addr[2]);
    assign scan_wrap = (cnt == CW'(SCAN_DIV - 1));
    assign O         = (asel == ADDR_CTRL) ? ctrl : data;

    always_comb begin
        data_nx = data;
        ctrl_nx = ctrl;
        for (int unsigned i = 0; i < 4; i++) begin
            if (WE && BE[i]) begin
                if (asel == ADDR_DATA) data_nx[8*i +: 8] = WD[8*i +: 8];
                else                   ctrl_nx[8*i +: 8] = WD[8*i +: 8];
            end
        end
        ctrl_nx = ctrl_nx & CTRL_WMASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            ctrl <= CTRL_RESET;
            cnt  <= '0;
            idx  <= '0;
        end else begin
            data <= data_nx;
            ctrl <= ctrl_nx;
            if (scan_wrap) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Group 1 shows digit idx+4, i.e. the upper half of DATA and of the dp mask.
    assign nib0   = 4'(data >> {idx, 2'b00});
    assign nib1   = 4'(data >> {1'b1, idx, 2'b00});
    assign dpmask = ctrl[CTRL_DP_LSB +: 8];

    hex_to_seg7 u_dec0 (.hex(nib0), .seg(glyph0));
    hex_to_seg7 u_dec1 (.hex(nib1), .seg(glyph1));

    always_comb begin
        sel_nx  = BLANK_SEL;
        seg0_nx = BLANK_SEG;
        seg1_nx = BLANK_SEG;
        if (ctrl[CTRL_EN]) begin
            sel_nx  = ~(4'b0001 << idx);
            seg0_nx = {~dpmask[{1'b0, idx}], ~glyph0};
            seg1_nx = {~dpmask[{1'b1, idx}], ~glyph1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel0 <= BLANK_SEL;
            sel1 <= BLANK_SEL;
            seg0 <= BLANK_SEG;
            seg1 <= BLANK_SEG;
        end else begin
            sel0 <= sel_nx;
            sel1 <= sel_nx;
            seg0 <= seg0_nx;
            seg1 <= seg1_nx;
        end
    end

endmodule

// File: tb/tb_digital_tube_ctrl.sv
// Randomized and directed bench for digital_tube_ctrl against a cycle-count reference model.
module tb_digital_tube_ctrl;

    localparam int SCAN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] O;
    logic [3:0]  sel0, sel1;
    logic [7:0]  seg0, seg1;

    digital_tube_ctrl #(.SCAN_DIV(SCAN)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .BE(BE), .WD(WD),
        .O(O), .sel0(sel0), .sel1(sel1), .seg0(seg0), .seg1(seg1)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [31:0] m_data, m_ctrl;
    int          ticks;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_idx();
        return (ticks / SCAN) % 4;
    endfunction

    // One clock: drive inputs, predict outputs from pre-edge model state, check, update model.
    task automatic step(input logic r, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
        logic [3:0]  e_sel;
        logic [7:0]  e_seg0, e_seg1;
        logic [31:0] word;
        int          k;
        reset = r; WE = we; Addr = addr; BE = be; WD = wd;
        e_sel = 4'hF; e_seg0 = 8'hFF; e_seg1 = 8'hFF;
        if (!r && m_ctrl[0]) begin
            k      = model_idx();
            e_sel  = ~(4'b0001 << k);
            e_seg0 = {~m_ctrl[8 + k],     ~glyph[(m_data >> (4 * k)) & 32'hF]};
            e_seg1 = {~m_ctrl[8 + k + 4], ~glyph[(m_data >> (4 * (k + 4))) & 32'hF]};
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_data = 32'h0;
            m_ctrl = 32'h1;
            ticks  = 0;
        end else begin
            if (we) begin
                word = addr[2] ? m_ctrl : m_data;
                for (int b = 0; b < 4; b++)
                    if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
                if (addr[2]) m_ctrl = word & 32'h0000_FF01;
                else         m_data = word;
            end
            ticks++;
        end
        check("sel0", {28'h0, sel0}, {28'h0, e_sel});
        check("sel1", {28'h0, sel1}, {28'h0, e_sel});
        check("seg0", {24'h0, seg0}, {24'h0, e_seg0});
        check("seg1", {24'h0, seg1}, {24'h0, e_seg1});
        check("O", O, addr[2] ? m_ctrl : m_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; WE = 1'b0; Addr = '0; BE = '0; WD = '0;
        m_data = 32'h0; m_ctrl = 32'h1; ticks = 0;

        // Reset and readback of reset values
        step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        check("rst_sel_blank", {28'h0, sel0}, 32'hF);
        check("rst_seg_blank", {24'h0, seg1}, 32'hFF);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("rst_data", O, 32'h0);
        check("first_sel", {28'h0, sel0}, 32'hE);
        step(1'b0, 1'b0, 32'h4, 4'h0, 32'h0);
        check("rst_ctrl", O, 32'h1);

        // Full-word write then a full scan cycle
        step(1'b0, 1'b1, 32'h0, 4'hF, 32'h8765_4321);
        idle(17);

        // Byte enables
        step(1'b0, 1'b1, 32'h0, 4'b0100, 32'hFFFF_FFFF);
        check("byte_en", O, 32'h87FF_4321);
        step(1'b0, 1'b1, 32'h0, 4'hF, 32'h8765_4321);

        // CTRL masking and decimal points
        step(1'b0, 1'b1, 32'h4, 4'hF, 32'hFFFF_FF01);
        check("ctrl_mask", O, 32'h0000_FF01);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 32'h4, 4'h0, 32'h0);
            check("dp0_lit", {31'h0, seg0[7]}, 32'h0);
            check("dp1_lit", {31'h0, seg1[7]}, 32'h0);
        end

        // Blanking and restore
        step(1'b0, 1'b1, 32'h4, 4'hF, 32'h0);
        idle(7);
        check("blank_sel", {28'h0, sel0}, 32'hF);
        step(1'b0, 1'b1, 32'h4, 4'h1, 32'h1);
        idle(9);

        // Reset with a simultaneous write at idx 2
        for (int i = 0; i < 40 && !(model_idx() == 2 && ticks % SCAN == 1); i++) idle(1);
        check("reach_idx2", model_idx(), 2);
        step(1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF);
        check("rst_over_we", O, 32'h0);
        idle(2);
        check("rst_idx0", {28'h0, sel0}, 32'hE);

        // Write landing on the idx-advance edge
        step(1'b0, 1'b1, 32'h0, 4'hF, 32'hABCD_EF01);
        for (int i = 0; i < 8 && (ticks % SCAN != SCAN - 1); i++) idle(1);
        step(1'b0, 1'b1, 32'h0, 4'hF, 32'h0F0F_A8A8);
        idle(1);
        check("adv_seg0", {24'h0, seg0}, {24'h0, 1'b1, ~glyph[4'hA]});

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                 {$urandom} & 32'h0000_000C, 4'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
